// File: rtl/lock_key_pkg.sv
// Shared definitions for the lock keypad interface: key codes, sequencer
// state encoding, default press timing and small elaboration helpers.
package lock_key_pkg;

  localparam logic [3:0] KEY_SET       = 4'hE;
  localparam logic [3:0] KEY_OPEN      = 4'hF;
  localparam logic [3:0] KEY_CONFIRM   = 4'hD;
  localparam logic [3:0] KEY_DIGIT_MIN = 4'h0;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  localparam int DEF_MAX_KEYS       = 8;
  localparam int DEF_SETUP_CYCLES   = 2;
  localparam int DEF_PRESS_CYCLES   = 10;
  localparam int DEF_RELEASE_CYCLES = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  // A zero-length phase would never expire, so it is stretched to one cycle.
  function automatic int min_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_key_press_timer.sv
// Down-counter shared by the SETUP, PRESS and RELEASE phases; expire is high
// in the last cycle of the loaded duration.
module lock_key_press_timer
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == ONE);

endmodule

// File: rtl/lock_key_sequencer.sv
// Replays a stored list of 4-bit key codes onto the lock keypad as timed,
// debouncer-friendly presses (Sw stable, key_in pulsed low once per code).
module lock_key_sequencer
  import lock_key_pkg::*;
#(
  parameter int MAX_KEYS       = DEF_MAX_KEYS,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int PRESS_CYCLES   = DEF_PRESS_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [3:0]            cmd_len,
  input  logic [4*MAX_KEYS-1:0] cmd_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [3:0]            key_idx,
  output logic [3:0]            Sw,
  output logic                  key_in
);

  localparam int SETUP_N   = min_one(SETUP_CYCLES);
  localparam int PRESS_N   = min_one(PRESS_CYCLES);
  localparam int RELEASE_N = min_one(RELEASE_CYCLES);
  localparam int CNT_W     = $clog2(max3(SETUP_N, PRESS_N, RELEASE_N) + 1);
  localparam int DATA_W    = 4 * MAX_KEYS;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_N);
  localparam logic [CNT_W-1:0] PRESS_LD   = CNT_W'(PRESS_N);
  localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_N);
  localparam logic [3:0]       MAX_LEN    = 4'((MAX_KEYS > 15) ? 15 : MAX_KEYS);

  state_t            state_r, state_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              aborted_r, aborted_s;
  logic [3:0]        key_idx_r, key_idx_s;
  logic [3:0]        sw_r, sw_s;
  logic              key_in_r, key_in_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [3:0]        len_r, len_s;

  logic              load_s;
  logic [CNT_W-1:0]  load_val_s;
  logic              expire_s;
  logic [3:0]        len_clamp_s;
  logic              last_key_s;
  logic              kill_s;
  logic [DATA_W-1:0] shifted_s;

  lock_key_press_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expire   (expire_s)
  );

  assign len_clamp_s = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign last_key_s  = (key_idx_r == (len_r - 4'd1));
  assign shifted_s   = shift_r >> 3'd4;
  // FINISH is excluded so that a late abort cannot suppress done.
  assign kill_s      = abort && ((state_r == ST_SETUP) ||
                                 (state_r == ST_PRESS) ||
                                 (state_r == ST_RELEASE));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    aborted_s  = 1'b0;
    key_idx_s  = key_idx_r;
    sw_s       = sw_r;
    key_in_s   = key_in_r;
    shift_s    = shift_r;
    len_s      = len_r;
    load_s     = 1'b0;
    load_val_s = '0;

    if (kill_s) begin
      state_s   = ST_IDLE;
      busy_s    = 1'b0;
      aborted_s = 1'b1;
      sw_s      = 4'h0;
      key_in_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          key_in_s = 1'b1;
          if (start) begin
            shift_s = cmd_data;
            len_s   = len_clamp_s;
            if (len_clamp_s == 4'd0) begin
              state_s = ST_FINISH;
            end else begin
              state_s    = ST_SETUP;
              busy_s     = 1'b1;
              key_idx_s  = 4'd0;
              sw_s       = cmd_data[3:0];
              load_s     = 1'b1;
              load_val_s = SETUP_LD;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (expire_s) begin
            state_s    = ST_PRESS;
            key_in_s   = 1'b0;
            load_s     = 1'b1;
            load_val_s = PRESS_LD;
          end else begin
            state_s = ST_SETUP;
          end
        end
        ST_PRESS: begin
          if (expire_s) begin
            state_s    = ST_RELEASE;
            key_in_s   = 1'b1;
            load_s     = 1'b1;
            load_val_s = RELEASE_LD;
          end else begin
            state_s = ST_PRESS;
          end
        end
        ST_RELEASE: begin
          if (expire_s && last_key_s) begin
            state_s = ST_FINISH;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            sw_s    = 4'h0;
          end else if (expire_s) begin
            state_s    = ST_SETUP;
            shift_s    = shifted_s;
            sw_s       = shifted_s[3:0];
            key_idx_s  = key_idx_r + 4'd1;
            load_s     = 1'b1;
            load_val_s = SETUP_LD;
          end else begin
            state_s = ST_RELEASE;
          end
        end
        ST_FINISH: begin
          // Entered with done already raised after a played sequence; the
          // zero-length path arrives with done low and raises it here.
          busy_s   = 1'b0;
          sw_s     = 4'h0;
          key_in_s = 1'b1;
          if (done_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          busy_s   = 1'b0;
          sw_s     = 4'h0;
          key_in_s = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      key_idx_r <= 4'd0;
      sw_r      <= 4'h0;
      key_in_r  <= 1'b1;
      shift_r   <= '0;
      len_r     <= 4'd0;
    end else begin
      state_r   <= state_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
      key_idx_r <= key_idx_s;
      sw_r      <= sw_s;
      key_in_r  <= key_in_s;
      shift_r   <= shift_s;
      len_r     <= len_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign aborted = aborted_r;
  assign key_idx = key_idx_r;
  assign Sw      = sw_r;
  assign key_in  = key_in_r;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Scoreboard bench for lock_key_sequencer: stimulus pushes expected press,
// done and abort events; a negedge monitor pops and compares them.
module tb_lock_key_sequencer;

  localparam int MAXK  = 8;
  localparam int SC    = 2;
  localparam int PC    = 10;
  localparam int RC    = 10;
  localparam int KEY_T = SC + PC + RC;
  localparam int DW    = 4 * MAXK;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [3:0]    cmd_len;
  logic [DW-1:0] cmd_data;
  logic          abort;
  logic          busy, done, aborted, key_in;
  logic [3:0]    key_idx, Sw;

  lock_key_sequencer #(
    .MAX_KEYS       (MAXK),
    .SETUP_CYCLES   (SC),
    .PRESS_CYCLES   (PC),
    .RELEASE_CYCLES (RC)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .key_idx  (key_idx),
    .Sw       (Sw),
    .key_in   (key_in)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS = 1, EV_DONE = 2, EV_ABORT = 3} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       code;
    int       idx;
    int       width;
    int       at_cyc;
    int       busy_len;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: what the lock should see for one command.
  task automatic push_expected(input int n, input logic [DW-1:0] data, input int cut_k,
                               input int cut_m, input bit cut_is_abort, input int s_cyc);
    ev_t e;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = data >> (4 * i);
      e = '{kind: EV_PRESS, code: int'(d[3:0]), idx: i, width: PC, at_cyc: 0, busy_len: 0};
      if (cut_k == i + 1) begin
        e.width = cut_m;
        exp_q.push_back(e);
        if (cut_is_abort) begin
          e = '{kind: EV_ABORT, code: 0, idx: 0, width: 0, at_cyc: 0, busy_len: 0};
          exp_q.push_back(e);
        end
        return;
      end
      exp_q.push_back(e);
    end
    e = '{kind: EV_DONE, code: 0, idx: 0, width: 0,
          at_cyc: s_cyc + ((n == 0) ? 2 : n * KEY_T + 1), busy_len: n * KEY_T};
    exp_q.push_back(e);
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  logic       in_press = 1'b0;
  logic       sw_stable = 1'b1;
  logic [3:0] press_sw = 4'h0;
  logic [3:0] press_idx = 4'h0;
  int         low_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge Clk) begin : monitor
    ev_t e;
    if (key_in === 1'b0) begin
      if (!in_press) begin
        in_press  = 1'b1;
        low_cnt   = 0;
        press_sw  = Sw;
        press_idx = key_idx;
        sw_stable = 1'b1;
      end else if (Sw !== press_sw) begin
        sw_stable = 1'b0;
      end
      low_cnt++;
    end else if (in_press) begin
      in_press = 1'b0;
      check("sw_stable_in_press", 32'(sw_stable), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_press", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("press_kind", int'(EV_PRESS), int'(e.kind));
        check("press_code", 32'(press_sw), e.code);
        check("press_idx", 32'(press_idx), e.idx);
        check("press_width", low_cnt, e.width);
      end
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", int'(EV_DONE), int'(e.kind));
        check("done_cycle", cyc, e.at_cyc);
        check("busy_len", busy_cnt, e.busy_len);
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
      busy_cnt = 0;
    end
    if (aborted === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_aborted", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("abort_kind", int'(EV_ABORT), int'(e.kind));
        check("abort_key_in", 32'(key_in), 32'd1);
        check("abort_sw", 32'(Sw), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
      end
      busy_cnt = 0;
    end
    if (Rst === 1'b1) busy_cnt = 0;
  end

  // mode: 0 plain, 1 abort in press k, 2 reset in press k, 3 start while busy,
  //       4 abort during the done cycle, 5 start and abort together
  task automatic run_cmd(input int len, input logic [DW-1:0] data, input int mode,
                         input int k, input int m);
    int   n, seen;
    bit   found;
    logic prev;
    n = (len > MAXK) ? MAXK : len;
    @(posedge Clk); #1;
    push_expected(n, data, (mode == 1 || mode == 2) ? k : 0, m, mode == 1, cyc);
    start    = 1'b1;
    cmd_len  = 4'(len);
    cmd_data = data;
    abort    = (mode == 5);
    @(posedge Clk); #1;
    start    = 1'b0;
    abort    = 1'b0;
    cmd_len  = 4'($urandom);
    cmd_data = DW'($urandom);
    found    = 1'b0;
    if (mode == 1 || mode == 2) begin
      seen = 0;
      prev = key_in;
      for (int t = 0; t < 4000 && !found; t++) begin
        @(posedge Clk); #1;
        if (prev === 1'b1 && key_in === 1'b0) begin
          seen++;
          found = (seen == k);
        end
        prev = key_in;
      end
      check("wait_press_found", 32'(found), 32'd1);
      repeat (m - 1) begin @(posedge Clk); #1; end
      if (mode == 1) abort = 1'b1;
      else Rst = 1'b1;
      @(posedge Clk); #1;
      abort = 1'b0;
      Rst   = 1'b0;
      if (mode == 2) begin
        check("rst_key_in", 32'(key_in), 32'd1);
        check("rst_sw", 32'(Sw), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_key_idx", 32'(key_idx), 32'd0);
      end
    end else if (mode == 3) begin
      for (int t = 0; t < 4000 && !found; t++) begin
        @(posedge Clk); #1;
        found = (key_idx === 4'd1);
      end
      check("wait_second_key", 32'(found), 32'd1);
      start    = 1'b1;
      cmd_len  = 4'($urandom_range(1, 15));
      cmd_data = DW'($urandom);
      @(posedge Clk); #1;
      start = 1'b0;
    end else if (mode == 4) begin
      for (int t = 0; t < 4000 && !found; t++) begin
        @(posedge Clk); #1;
        found = (done === 1'b1);
      end
      check("wait_done_pulse", 32'(found), 32'd1);
      abort = 1'b1;
      @(posedge Clk); #1;
      abort = 1'b0;
    end
    for (int t = 0; t < 4000 && exp_q.size() != 0; t++) begin
      @(posedge Clk); #1;
    end
    check("events_drained", exp_q.size(), 32'd0);
    repeat (3) begin @(posedge Clk); #1; end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int len, k;
    Rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cmd_len  = 4'd0;
    cmd_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_aborted", 32'(aborted), 32'd0);
    check("reset_key_idx", 32'(key_idx), 32'd0);
    check("reset_sw", 32'(Sw), 32'd0);
    check("reset_key_in", 32'(key_in), 32'd1);
    Rst = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end

    // set and open scripts
    run_cmd(6, 32'h00D4321E, 0, 0, 0);
    run_cmd(6, 32'h00D5325F, 0, 0, 0);
    run_cmd(6, 32'h00D4321F, 0, 0, 0);
    // degenerate lengths
    run_cmd(0, 32'h12345678, 0, 0, 0);
    run_cmd(12, 32'hA9876543, 0, 0, 0);
    run_cmd(8, 32'hFEDCBA98, 0, 0, 0);
    run_cmd(1, 32'h0000000E, 0, 0, 0);
    // abort in idle must not produce anything
    abort = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end
    abort = 1'b0;
    // abort mid-press, then a normal command
    run_cmd(6, 32'h00D4321E, 1, 3, 5);
    run_cmd(6, 32'h00D4321E, 0, 0, 0);
    // start while busy, abort in done cycle, start+abort together
    run_cmd(6, 32'h00D4321E, 3, 0, 0);
    run_cmd(3, 32'h00000D21, 4, 0, 0);
    run_cmd(4, 32'h00004321, 5, 0, 0);
    // reset during a press, then replay from code 0
    run_cmd(5, 32'h0005A1B2, 2, 2, 4);
    run_cmd(5, 32'h0005A1B2, 0, 0, 0);
    // randomized commands and aborts
    for (int r = 0; r < 8; r++) begin
      run_cmd($urandom_range(0, 15), DW'($urandom), 0, 0, 0);
    end
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, MAXK);
      k   = $urandom_range(1, len);
      run_cmd(len, DW'($urandom), 1, k, $urandom_range(1, PC - 1));
    end

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_key_sequencer.md
Name: lock_key_sequencer

Overview:
- Transmit end of the lock's keypad interface: replays a stored sequence of 4-bit key codes onto Sw/key_in, one timed press per code.
- Timing matches what the lock's key debouncer accepts.
- Used in the lock_design_prj bring-up image (auto set/open scripts) and as the synthesizable stimulus source for lock regression benches.
- Single clock domain.

Parameters:
- MAX_KEYS, 8: maximum codes per command; cmd_data holds 4*MAX_KEYS bits.
- SETUP_CYCLES, 2: cycles Sw is stable with key_in high before each press.
- PRESS_CYCLES, 10: cycles key_in is held low per press (200 ns at 50 MHz).
- RELEASE_CYCLES, 10: cycles key_in is held high after each press.

Ports:
- Clk, input, 1: system clock, rising edge.
- Rst, input, 1: synchronous reset, active-high.
- start, input, 1: one-cycle command strobe; sampled only in IDLE.
- cmd_len, input, 4: number of codes to play.
- cmd_data, input, 4*MAX_KEYS: codes to play; code 0 is in [3:0] and plays first.
- abort, input, 1: terminate the current command.
- busy, output, 1: high while a command is in progress.
- done, output, 1: one-cycle pulse when a command completes normally.
- aborted, output, 1: one-cycle pulse when a command is terminated by abort.
- key_idx, output, 4: index of the code currently being played.
- Sw, output, 4: key code presented to the lock.
- key_in, output, 1: key strobe to the lock, active-low (1 = released).

Behaviour:
- All outputs are registered. Clock Clk; reset Rst is synchronous and active-high.
- Reset values: busy=0, done=0, aborted=0, key_idx=0, Sw=0, key_in=1, state=IDLE.
- States: IDLE, SETUP, PRESS, RELEASE, FINISH.
- A single down-counter, wide enough for max(SETUP,PRESS,RELEASE), times every state.
- IDLE, start=1:
  - Latch cmd_data into a shift register.
  - Latch len = min(cmd_len, MAX_KEYS).
  - If len=0: go to FINISH, so done pulses 2 cycles after start and no press is emitted.
  - Otherwise: at the next edge busy=1, key_idx=0, Sw=code0, state=SETUP.
- SETUP: key_in=1 for SETUP_CYCLES cycles, then go to PRESS.
- PRESS: key_in=0 for exactly PRESS_CYCLES cycles, then go to RELEASE. Sw does not change during SETUP or PRESS.
- RELEASE: key_in=1 for RELEASE_CYCLES cycles, then:
  - more codes remain: shift to the next code, Sw=next code, key_idx+1, go to SETUP;
  - last code played: go to FINISH.
- Sw changes only on the RELEASE->SETUP edge or the IDLE->SETUP edge, never while key_in=0.
- FINISH: done=1 for one cycle, busy=0, Sw=0, return to IDLE.
- busy is high for exactly len*(SETUP_CYCLES+PRESS_CYCLES+RELEASE_CYCLES) cycles.
- start while busy is ignored: no queuing, no effect on the running command.
- abort while busy, in any state other than FINISH:
  - next edge: key_in=1, Sw=0, busy=0, aborted=1 for one cycle, state=IDLE.
  - An in-progress press is truncated. The lock then sees a short press, which its debouncer rejects.
- abort in IDLE is ignored.
- abort coinciding with the FINISH cycle: done wins and aborted is not asserted.
- start and abort together in IDLE: start is accepted and abort is ignored.
- Rst asserted mid-press: key_in=1 and all outputs take reset values at that edge; no done or aborted pulse.
- Counter reload happens on each state entry. A parameter value of 0 is treated as 1, so every state lasts at least one cycle.

Decomposition:
- Package lock_key_pkg, shared with the lock RT:
  - KEY_SET=4'hE, KEY_OPEN=4'hF, KEY_CONFIRM=4'hD;
  - the digit range 4'h0–4'h9;
  - state encoding typedef;
  - default timing constants.
- One natural sub-module: lock_key_press_timer. It takes a load value and a load strobe and produces expire; instantiate it once and reuse it for all three timed states.

Test Plan:
- Set-code script: SETUP=2, PRESS=10, RELEASE=10, cmd_len=6, codes E,1,2,3,4,D -> six key_in low pulses of exactly 10 cycles each; Sw reads E,1,2,3,4,D during the pulses; busy high for 132 cycles; done pulses once at cycle 133 after start.
- Chained with lock_design_prj: set script E,1,2,3,4,D, then open script F,5,2,3,5,D -> ERROR_sig asserts. Then replay E,1,2,3,4,D (set) followed by F,1,2,3,4,D (open) -> OPEN_sig asserts.
- Degenerate lengths: cmd_len=0 -> key_in stays 1 and done occurs 2 cycles after start. cmd_len=12 with MAX_KEYS=8 -> exactly 8 presses.
- Abort mid-press: abort asserted at cycle 5 of the third PRESS -> next edge key_in=1, Sw=0, aborted=1, busy=0, done never asserts. The following start is accepted normally.
- Start while busy: a second start during the 2nd key -> ignored; the original sequence and total busy length are unchanged.
- Reset: Rst pulsed while key_in=0 -> key_in=1 and Sw=0 at that edge, with no done or aborted pulse. A new command afterwards plays from code 0.
